isa_fetch_cache: RTL and testbench

Instruction-side cache that sits directly upstream of the DDR3 interface top and serves the processor's fetch stage. It holds one window of ISA_DEPTH consecutive instructions. On a miss it issues an ISA burst read of ISA_DEPTH beats and fills the window from instruction_to_cache. It then answers the pending fetch and returns to serving hits with 1-cycle latency.

---
 rtl/isa_cache_pkg.sv | 9 +
 rtl/isa_line_ram.sv | 26 ++
 rtl/isa_fetch_cache.sv | 98 +++++++++
 tb/tb_isa_fetch_cache.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/isa_cache_pkg.sv
// isa_cache_pkg: shared state encoding and width constants for the instruction fetch cache
package isa_cache_pkg;
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_REQ, S_FILL, S_RESP} state_t;
  localparam int LEN_W = 10;
  function automatic int off_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
  localparam int OFF_W = off_w(72);
endpackage

// File: rtl/isa_line_ram.sv
// isa_line_ram: single-window instruction storage, one write port and one registered read port
module isa_line_ram
  import isa_cache_pkg::*;
#(
  parameter int DEPTH = 72,
  parameter int WIDTH = 30,
  parameter int AW = OFF_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  // storage write, deliberately without reset
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // read register only updates on an actual read so returned data stays stable
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/isa_fetch_cache.sv
// isa_fetch_cache: one-window instruction cache that refills from a DDR burst on a miss
module isa_fetch_cache
  import isa_cache_pkg::*;
#(
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int ISA_WIDTH = 30,
  parameter int ISA_DEPTH = 72,
  parameter int ADDR_SHIFT = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      init_calib_complete,
  input  logic                      fetch_req,
  input  logic [DDR_ADDR_WIDTH-1:0] fetch_addr,
  output logic                      fetch_ready,
  output logic                      fetch_valid,
  output logic [ISA_WIDTH-1:0]      fetch_data,
  input  logic                      flush,
  output logic                      ISA_read_req,
  output logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr,
  output logic [LEN_W-1:0]          isa_read_len,
  input  logic [ISA_WIDTH-1:0]      instruction_to_cache,
  input  logic                      rd_burst_data_valid
);
  localparam int OW = off_w(ISA_DEPTH);
  state_t state;
  logic valid, flush_pending, hit, we, re, last;
  logic [DDR_ADDR_WIDTH-1:0] base, miss_addr, diff;
  logic [OW-1:0] fill_cnt, raddr;
  assign isa_read_len = LEN_W'(ISA_DEPTH);
  // hit test uses a full-width unsigned offset; the >= guard prevents wrap-around hits
  always_comb begin
    diff = fetch_addr - base;
    hit = valid && fetch_addr >= base && diff < DDR_ADDR_WIDTH'(ISA_DEPTH);
    last = fill_cnt == OW'(ISA_DEPTH - 1);
    we = rd_burst_data_valid && (state == S_REQ || state == S_FILL);
    re = state == S_RESP || (state == S_IDLE && fetch_req && hit);
    raddr = state == S_RESP ? '0 : diff[OW-1:0];
  end
  isa_line_ram #(.DEPTH(ISA_DEPTH), .WIDTH(ISA_WIDTH), .AW(OW)) u_ram (
    .clk(clk), .rst(rst), .we(we), .waddr(fill_cnt), .wdata(instruction_to_cache),
    .re(re), .raddr(raddr), .rdata(fetch_data)
  );
  // control FSM with registered handshake and DDR request outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_INIT;
      fetch_ready <= 1'b0;
      fetch_valid <= 1'b0;
      ISA_read_req <= 1'b0;
      ISA_read_addr <= '0;
      valid <= 1'b0;
      flush_pending <= 1'b0;
      base <= '0;
      miss_addr <= '0;
      fill_cnt <= '0;
    end else begin
      fetch_valid <= 1'b0;
      case (state)
        S_INIT: if (init_calib_complete) begin
          state <= S_IDLE;
          fetch_ready <= 1'b1;
        end
        S_IDLE: begin
          if (flush) valid <= 1'b0;
          if (fetch_req && hit) fetch_valid <= 1'b1;
          else if (fetch_req) begin
            miss_addr <= fetch_addr;
            ISA_read_addr <= fetch_addr << ADDR_SHIFT;
            ISA_read_req <= 1'b1;
            fill_cnt <= '0;
            fetch_ready <= 1'b0;
            state <= S_REQ;
          end
        end
        S_REQ, S_FILL: begin
          if (flush) flush_pending <= 1'b1;
          if (rd_burst_data_valid) begin
            ISA_read_req <= 1'b0;
            fill_cnt <= fill_cnt + OW'(1);
            state <= last ? S_RESP : S_FILL;
            if (last) begin
              base <= miss_addr;
              valid <= !(flush_pending || flush);
            end
          end
        end
        S_RESP: begin
          if (flush) valid <= 1'b0;
          fetch_valid <= 1'b1;
          fetch_ready <= 1'b1;
          flush_pending <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
endmodule

// File: tb/tb_isa_fetch_cache.sv
// tb_isa_fetch_cache: randomized self-checking bench with a window-level reference model
module tb_isa_fetch_cache;
  localparam int AW = 28, IW = 30, D = 72, SH = 3;
  logic clk = 1'b0;
  logic rst, init_calib_complete, fetch_req, flush, rd_burst_data_valid;
  logic [AW-1:0] fetch_addr;
  logic fetch_ready, fetch_valid, ISA_read_req;
  logic [IW-1:0] fetch_data, instruction_to_cache;
  logic [AW-1:0] ISA_read_addr;
  logic [9:0] isa_read_len;
  int passed = 0, total = 0;
  logic [IW-1:0] model_mem [D];
  longint model_base;
  bit model_valid;
  logic [IW-1:0] key;

  always #5 clk = ~clk;

  isa_fetch_cache dut (
    .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .flush(flush),
    .ISA_read_req(ISA_read_req), .ISA_read_addr(ISA_read_addr), .isa_read_len(isa_read_len),
    .instruction_to_cache(instruction_to_cache), .rd_burst_data_valid(rd_burst_data_valid)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IW-1:0] ddr_word(input longint idx);
    return IW'(idx) ^ key;
  endfunction

  function automatic bit model_hit(input longint a);
    return model_valid && a >= model_base && a - model_base < D;
  endfunction

  // one fetch; on a miss plays the DDR side with random gaps and optional flush at a given beat
  task automatic do_fetch(input longint a, input int flush_beat, input bit flush_now);
    bit hit, fp;
    int gap;
    logic [AW-1:0] exp_addr;
    hit = model_hit(a);
    exp_addr = AW'(a << SH);
    total++; if (fetch_ready !== 1'b1) $display("FAIL ready_before a=%h got %b want 1", a, fetch_ready); else passed++;
    fetch_req = 1'b1; fetch_addr = AW'(a); flush = flush_now;
    tick;
    fetch_req = 1'b0; flush = 1'b0;
    if (hit) begin
      total++; if (fetch_valid !== 1'b1) $display("FAIL hit_valid a=%h got %b want 1", a, fetch_valid); else passed++;
      total++; if (fetch_data !== model_mem[a - model_base]) $display("FAIL hit_data a=%h got %h want %h", a, fetch_data, model_mem[a - model_base]); else passed++;
      if (flush_now) model_valid = 1'b0;
      return;
    end
    total++; if (fetch_valid !== 1'b0) $display("FAIL miss_no_valid a=%h got %b want 0", a, fetch_valid); else passed++;
    total++; if (fetch_ready !== 1'b0) $display("FAIL miss_ready a=%h got %b want 0", a, fetch_ready); else passed++;
    total++; if (ISA_read_req !== 1'b1) $display("FAIL miss_req a=%h got %b want 1", a, ISA_read_req); else passed++;
    total++; if (ISA_read_addr !== exp_addr) $display("FAIL miss_addr a=%h got %h want %h", a, ISA_read_addr, exp_addr); else passed++;
    total++; if (isa_read_len !== 10'd72) $display("FAIL read_len got %0d want 72", isa_read_len); else passed++;
    gap = $urandom_range(0, 4);
    repeat (gap) begin
      tick;
      total++; if (ISA_read_req !== 1'b1) $display("FAIL req_hold a=%h got %b want 1", a, ISA_read_req); else passed++;
    end
    fp = 1'b0;
    for (int i = 0; i < D; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        rd_burst_data_valid = 1'b0; instruction_to_cache = IW'($urandom);
        tick;
      end
      rd_burst_data_valid = 1'b1;
      instruction_to_cache = ddr_word(a + i);
      model_mem[i] = instruction_to_cache;
      flush = (i == flush_beat);
      if (i == flush_beat) fp = 1'b1;
      tick;
      flush = 1'b0;
      if (i == 0) begin
        total++; if (ISA_read_req !== 1'b0) $display("FAIL req_drop a=%h got %b want 0", a, ISA_read_req); else passed++;
      end
    end
    rd_burst_data_valid = 1'b0;
    total++; if (fetch_valid !== 1'b0) $display("FAIL early_valid a=%h got %b want 0", a, fetch_valid); else passed++;
    tick;
    total++; if (fetch_valid !== 1'b1) $display("FAIL miss_valid a=%h got %b want 1", a, fetch_valid); else passed++;
    total++; if (fetch_data !== model_mem[0]) $display("FAIL miss_data a=%h got %h want %h", a, fetch_data, model_mem[0]); else passed++;
    total++; if (fetch_ready !== 1'b1) $display("FAIL ready_after a=%h got %b want 1", a, fetch_ready); else passed++;
    model_base = a;
    model_valid = !fp;
  endtask

  task automatic test_reset;
    total++; if (fetch_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", fetch_ready); else passed++;
    total++; if (fetch_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", fetch_valid); else passed++;
    total++; if (fetch_data !== '0) $display("FAIL rst_data got %h want 0", fetch_data); else passed++;
    total++; if (ISA_read_req !== 1'b0) $display("FAIL rst_req got %b want 0", ISA_read_req); else passed++;
    total++; if (ISA_read_addr !== '0) $display("FAIL rst_addr got %h want 0", ISA_read_addr); else passed++;
    total++; if (isa_read_len !== 10'd72) $display("FAIL rst_len got %0d want 72", isa_read_len); else passed++;
  endtask

  task automatic test_calib;
    fetch_req = 1'b1; fetch_addr = 28'h100;
    repeat (50) begin
      tick;
      total++; if (fetch_ready !== 1'b0 || ISA_read_req !== 1'b0) $display("FAIL calib_gate got ready=%b req=%b want 0/0", fetch_ready, ISA_read_req); else passed++;
    end
    fetch_req = 1'b0;
    init_calib_complete = 1'b1;
    tick;
    total++; if (fetch_ready !== 1'b1) $display("FAIL calib_ready got %b want 1", fetch_ready); else passed++;
  endtask

  task automatic test_hit_stream;
    for (int i = 0; i < D; i++) begin
      fetch_req = 1'b1; fetch_addr = AW'(model_base + i);
      tick;
      total++; if (fetch_valid !== 1'b1 || fetch_data !== model_mem[i] || ISA_read_req !== 1'b0)
        $display("FAIL stream i=%0d got v=%b d=%h req=%b want 1/%h/0", i, fetch_valid, fetch_data, ISA_read_req, model_mem[i]); else passed++;
    end
    fetch_req = 1'b0;
    tick;
    total++; if (fetch_valid !== 1'b0) $display("FAIL stream_end got %b want 0", fetch_valid); else passed++;
  endtask

  task automatic test_stray_beats;
    repeat (10) begin
      rd_burst_data_valid = 1'b1; instruction_to_cache = IW'($urandom);
      tick;
      total++; if (ISA_read_req !== 1'b0 || fetch_ready !== 1'b1) $display("FAIL stray_idle got req=%b ready=%b want 0/1", ISA_read_req, fetch_ready); else passed++;
    end
    rd_burst_data_valid = 1'b0;
    test_hit_stream;
  endtask

  task automatic test_random;
    longint a;
    key = IW'($urandom);
    repeat (30) begin
      if ($urandom_range(0, 7) == 0) a = longint'($urandom_range(0, 32'h0FFF_FFFF));
      else begin
        a = model_base + $urandom_range(0, 110) - 20;
        if (a < 0) a = 0;
        if (a > 64'h0FFF_FFFF) a = 64'h0FFF_FFFF;
      end
      do_fetch(a, -1, 1'b0);
    end
  endtask

  task automatic test_wrap;
    do_fetch(64'h0FFF_FFF6, -1, 1'b0);
    do_fetch(64'h0FFF_FFFF, -1, 1'b0);
    do_fetch(64'h0000_0003, -1, 1'b0);
  endtask

  task automatic test_reset_mid_fill;
    fetch_req = 1'b1; fetch_addr = 28'h500;
    tick;
    fetch_req = 1'b0;
    total++; if (ISA_read_req !== 1'b1) $display("FAIL rmf_req got %b want 1", ISA_read_req); else passed++;
    for (int i = 0; i < 40; i++) begin
      rd_burst_data_valid = 1'b1; instruction_to_cache = ddr_word(28'h500 + i);
      tick;
    end
    rst = 1'b1; init_calib_complete = 1'b0;
    tick;
    rst = 1'b0;
    test_reset;
    repeat (32) begin
      rd_burst_data_valid = 1'b1; instruction_to_cache = IW'($urandom);
      tick;
      total++; if (fetch_ready !== 1'b0 || ISA_read_req !== 1'b0 || fetch_valid !== 1'b0)
        $display("FAIL rmf_stray got ready=%b req=%b v=%b want 0/0/0", fetch_ready, ISA_read_req, fetch_valid); else passed++;
    end
    rd_burst_data_valid = 1'b0;
    model_valid = 1'b0;
    init_calib_complete = 1'b1;
    tick;
    total++; if (fetch_ready !== 1'b1) $display("FAIL rmf_recal got %b want 1", fetch_ready); else passed++;
    do_fetch(28'h500, -1, 1'b0);
    do_fetch(28'h547, -1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; init_calib_complete = 1'b0; fetch_req = 1'b0; flush = 1'b0;
    rd_burst_data_valid = 1'b0; fetch_addr = '0; instruction_to_cache = '0;
    key = '0; model_valid = 1'b0; model_base = 0;
    repeat (3) tick;
    test_reset;
    rst = 1'b0;
    test_calib;
    do_fetch(28'h100, -1, 1'b0);
    test_hit_stream;
    do_fetch(28'h148, -1, 1'b0);
    do_fetch(28'h0FF, -1, 1'b0);
    do_fetch(28'h300, 30, 1'b0);
    do_fetch(28'h300, -1, 1'b0);
    do_fetch(28'h305, -1, 1'b1);
    do_fetch(28'h305, -1, 1'b0);
    test_stray_beats;
    test_random;
    test_wrap;
    test_reset_mid_fill;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
